// File: rtl/mag_cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM encoding
// and the chunk-count helper used to size the chunk index.
package mag_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nchunk_f(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/mag_cmp_chunk.sv
// Combinational CHUNK-bit unsigned compare. Flipping the MSB of both operands
// maps two's-complement ordering onto unsigned ordering for the top chunk.
module mag_cmp_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             inv_msb,
  output logic             gt,
  output logic             lt
);

  logic [CHUNK-1:0] a_x;
  logic [CHUNK-1:0] b_x;

  always_comb begin
    a_x            = a;
    b_x            = b;
    a_x[CHUNK-1]   = a[CHUNK-1] ^ inv_msb;
    b_x[CHUNK-1]   = b[CHUNK-1] ^ inv_msb;
  end

  assign gt = (a_x > b_x);
  assign lt = (a_x < b_x);

endmodule

// File: rtl/mag_cmp_seq.sv
// Multi-cycle magnitude comparator, CHUNK bits per cycle, MSB chunk first.
// Define MAG_CMP_EARLY_EXIT_EN to finish on the first differing chunk.
module mag_cmp_seq
  import mag_cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             busy
);

  localparam int NCHUNK = nchunk_f(WIDTH, CHUNK);
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0 || NCHUNK < 1) begin : g_bad_cfg
    $error("mag_cmp_seq: WIDTH must be a positive multiple of CHUNK");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic              sgn_q, sgn_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              decided_q, decided_d;
  logic              dgt_q, dgt_d, dlt_q, dlt_d;
  logic              gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;

  logic [WIDTH-1:0]  a_sh, b_sh;
  logic              c_gt, c_lt;
  logic              new_hit, finish, fin_gt, fin_lt;

  assign a_sh = a_q >> (idx_q * CHUNK);
  assign b_sh = b_q >> (idx_q * CHUNK);

  mag_cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a       (a_sh[CHUNK-1:0]),
    .b       (b_sh[CHUNK-1:0]),
    .inv_msb (sgn_q & (idx_q == IDX_TOP)),
    .gt      (c_gt),
    .lt      (c_lt)
  );

  // Once a chunk has decided, lower chunks no longer influence the result.
  assign new_hit = !decided_q && (c_gt || c_lt);
  assign fin_gt  = decided_q ? dgt_q : c_gt;
  assign fin_lt  = decided_q ? dlt_q : c_lt;
`ifdef MAG_CMP_EARLY_EXIT_EN
  assign finish  = (idx_q == '0) || new_hit;
`else
  assign finish  = (idx_q == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      idx_q     <= IDX_TOP;
      decided_q <= 1'b0;
      dgt_q     <= 1'b0;
      dlt_q     <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      dgt_q     <= dgt_d;
      dlt_q     <= dlt_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    dgt_d     = dgt_q;
    dlt_d     = dlt_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    eq_d      = eq_q;
    if (flush) begin
      // Drop any in-flight or pending result; visible result bits stay put.
      state_d   = IDLE;
      idx_d     = IDX_TOP;
      decided_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_d       = a;
            b_d       = b;
            sgn_d     = signed_mode;
            idx_d     = IDX_TOP;
            decided_d = 1'b0;
            dgt_d     = 1'b0;
            dlt_d     = 1'b0;
            state_d   = BUSY;
          end
        end
        BUSY: begin
          if (new_hit) begin
            decided_d = 1'b1;
            dgt_d     = c_gt;
            dlt_d     = c_lt;
          end
          if (finish) begin
            state_d = DONE;
            gt_d    = fin_gt;
            lt_d    = fin_lt;
            eq_d    = !(fin_gt || fin_lt);
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == BUSY);
    out_valid = (state_q == DONE);
    a_gt_b    = gt_q;
    a_lt_b    = lt_q;
    a_eq_b    = eq_q;
  end

endmodule

// File: tb/tb_mag_cmp_seq.sv
// Directed bench for mag_cmp_seq (WIDTH=16, CHUNK=4); latency expectations
// follow MAG_CMP_EARLY_EXIT_EN when it is defined.
module tb_mag_cmp_seq;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
`ifdef MAG_CMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             signed_mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             a_gt_b, a_lt_b, a_eq_b, busy;

  int vectors = 0;
  int miscompares = 0;

  mag_cmp_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .a_gt_b      (a_gt_b),
    .a_lt_b      (a_lt_b),
    .a_eq_b      (a_eq_b),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic accept(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic sm);
    @(negedge clk);
    a = av; b = bv; signed_mode = sm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handshake();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({in_ready, out_valid, busy, a_gt_b, a_lt_b, a_eq_b} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_hold: got %b want 100000",
               {in_ready, out_valid, busy, a_gt_b, a_lt_b, a_eq_b});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_release: got %b want 100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_unsigned_gt();
    int n;
    accept(16'h1234, 16'h1230, 1'b0);
    wait_done(n);
    vectors++;
    if (n !== 4) begin
      miscompares++;
      $display("FAIL gt_latency: got %0d want 4", n);
    end
    vectors++;
    if ({a_gt_b, a_lt_b, a_eq_b} !== 3'b100) begin
      miscompares++;
      $display("FAIL gt_result: got %b want 100", {a_gt_b, a_lt_b, a_eq_b});
    end
    handshake();
    vectors++;
    if ({in_ready, out_valid, a_gt_b, a_lt_b, a_eq_b} !== 5'b10100) begin
      miscompares++;
      $display("FAIL gt_after_hs: got %b want 10100",
               {in_ready, out_valid, a_gt_b, a_lt_b, a_eq_b});
    end
  endtask

  task automatic test_signed_boundary();
    int n;
    int want_n;
    logic [2:0] want_r;
    want_n = EE ? 1 : 4;
    for (int sm = 0; sm < 2; sm++) begin
      want_r = (sm == 1) ? 3'b010 : 3'b100;
      accept(16'h8000, 16'h7FFF, sm[0]);
      wait_done(n);
      vectors++;
      if (n !== want_n) begin
        miscompares++;
        $display("FAIL bnd_latency_sm%0d: got %0d want %0d", sm, n, want_n);
      end
      vectors++;
      if ({a_gt_b, a_lt_b, a_eq_b} !== want_r) begin
        miscompares++;
        $display("FAIL bnd_result_sm%0d: got %b want %b", sm,
                 {a_gt_b, a_lt_b, a_eq_b}, want_r);
      end
      handshake();
      vectors++;
      if ({in_ready, out_valid} !== 2'b10) begin
        miscompares++;
        $display("FAIL bnd_hs_sm%0d: got %b want 10", sm, {in_ready, out_valid});
      end
    end
  endtask

  task automatic test_equal_hold();
    int n;
    for (int sm = 0; sm < 2; sm++) begin
      accept(16'hBEEF, 16'hBEEF, sm[0]);
      a = 16'h0000; b = 16'hFFFF; in_valid = 1'b1;
      vectors++;
      if ({busy, in_ready, out_valid} !== 3'b100) begin
        miscompares++;
        $display("FAIL eq_busy_sm%0d: got %b want 100", sm, {busy, in_ready, out_valid});
      end
      wait_done(n);
      vectors++;
      if (n !== 4) begin
        miscompares++;
        $display("FAIL eq_latency_sm%0d: got %0d want 4", sm, n);
      end
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        vectors++;
        if ({out_valid, in_ready, a_gt_b, a_lt_b, a_eq_b} !== 5'b10001) begin
          miscompares++;
          $display("FAIL eq_hold_sm%0d_c%0d: got %b want 10001", sm, c,
                   {out_valid, in_ready, a_gt_b, a_lt_b, a_eq_b});
        end
      end
      in_valid = 1'b0;
      handshake();
      vectors++;
      if ({in_ready, out_valid, busy, a_eq_b} !== 4'b1001) begin
        miscompares++;
        $display("FAIL eq_after_hs_sm%0d: got %b want 1001", sm,
                 {in_ready, out_valid, busy, a_eq_b});
      end
    end
  endtask

  task automatic test_flush();
    int n;
    bit seen;
    accept(16'h0001, 16'h0002, 1'b0);
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_pre_busy: got %b want 1", busy);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    vectors++;
    if ({in_ready, busy, out_valid, a_gt_b, a_lt_b, a_eq_b} !== 6'b100001) begin
      miscompares++;
      $display("FAIL flush_idle: got %b want 100001",
               {in_ready, busy, out_valid, a_gt_b, a_lt_b, a_eq_b});
    end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_no_valid: got %b want 0", seen);
    end
    accept(16'hFFFF, 16'h0000, 1'b1);
    wait_done(n);
    vectors++;
    if (n !== (EE ? 1 : 4)) begin
      miscompares++;
      $display("FAIL post_flush_latency: got %0d want %0d", n, EE ? 1 : 4);
    end
    vectors++;
    if ({a_gt_b, a_lt_b, a_eq_b} !== 3'b010) begin
      miscompares++;
      $display("FAIL post_flush_result: got %b want 010", {a_gt_b, a_lt_b, a_eq_b});
    end
    handshake();
  endtask

  task automatic test_flush_in_idle();
    @(negedge clk);
    a = 16'h0005; b = 16'h0003; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({in_ready, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL flush_idle_accept: got %b want 10", {in_ready, busy});
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({busy, out_valid, a_lt_b} !== 3'b001) begin
      miscompares++;
      $display("FAIL flush_idle_after: got %b want 001", {busy, out_valid, a_lt_b});
    end
  endtask

  task automatic test_reset_mid_busy();
    int n;
    accept(16'h1234, 16'h1230, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, out_valid, busy, a_gt_b, a_lt_b, a_eq_b} !== 6'b100000) begin
      miscompares++;
      $display("FAIL rst_mid: got %b want 100000",
               {in_ready, out_valid, busy, a_gt_b, a_lt_b, a_eq_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL rst_release: got %b want 100", {in_ready, out_valid, busy});
    end
    accept(16'h0010, 16'h0100, 1'b0);
    wait_done(n);
    vectors++;
    if (n !== (EE ? 2 : 4)) begin
      miscompares++;
      $display("FAIL rst_new_latency: got %0d want %0d", n, EE ? 2 : 4);
    end
    vectors++;
    if ({a_gt_b, a_lt_b, a_eq_b} !== 3'b010) begin
      miscompares++;
      $display("FAIL rst_new_result: got %b want 010", {a_gt_b, a_lt_b, a_eq_b});
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_unsigned_gt();
    test_signed_boundary();
    test_equal_hold();
    test_flush();
    test_flush_in_idle();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, %0d vectors applied", vectors);
    $fatal(1, "timeout");
  end

endmodule
